// File: rtl/hazard_unit_if.sv
// Handshake bundle between the pipeline datapath and the hazard unit.
// The master side drives pipeline status; the slave side (hazard unit) drives enables and flushes.
interface hazard_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_branch;
    logic             id_taken;
    logic [4:0]       ex_wsel;
    logic             ex_regwr;
    logic             ex_memread;
    logic [4:0]       mem_wsel;
    logic             mem_memread;
    logic             mem_memop;
    logic             wb_halt;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output ihit, dhit, id_rs, id_rt, id_uses_rt, id_branch, id_taken,
               ex_wsel, ex_regwr, ex_memread, mem_wsel, mem_memread, mem_memop, wb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted, stall_cycles
    );

    modport slave (
        input  ihit, dhit, id_rs, id_rt, id_uses_rt, id_branch, id_taken,
               ex_wsel, ex_regwr, ex_memread, mem_wsel, mem_memread, mem_memop, wb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted, stall_cycles
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use / branch interlocks, dcache-miss freeze, halt, and a
// saturating stalled-cycle counter. All control outputs are Mealy and react in the same cycle.
module hazard_unit #(
    parameter int unsigned CNT_W = 16
) (
    input logic         CLK,
    input logic         RST,
    hazard_unit_if.slave hif
);
    typedef enum logic [1:0] {StRun, StStall, StMemWait, StHalt} state_e;

    state_e           state_q, state_d, saved_q, saved_d;
    logic [1:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q;

    logic ex_rs, ex_rt, mem_rs, mem_rt;
    logic lu, bl, ba, bm, dmiss;

    // Register zero never carries a dependency.
    assign ex_rs  = (hif.id_rs != 5'd0) && (hif.ex_wsel == hif.id_rs);
    assign ex_rt  = (hif.id_rt != 5'd0) && (hif.ex_wsel == hif.id_rt);
    assign mem_rs = (hif.id_rs != 5'd0) && (hif.mem_wsel == hif.id_rs);
    assign mem_rt = (hif.id_rt != 5'd0) && (hif.mem_wsel == hif.id_rt);

    assign lu    = hif.ex_memread && (hif.ex_wsel != 5'd0) && (ex_rs || (hif.id_uses_rt && ex_rt));
    assign bl    = hif.id_branch && hif.ex_memread && (ex_rs || ex_rt);
    assign ba    = hif.id_branch && hif.ex_regwr && !hif.ex_memread && (ex_rs || ex_rt);
    assign bm    = hif.id_branch && hif.mem_memread && (mem_rs || mem_rt);
    assign dmiss = hif.mem_memop && !hif.dhit;

    always_comb begin
        state_d         = state_q;
        saved_d         = saved_q;
        rem_d           = rem_q;
        hif.pc_en       = 1'b1;
        hif.ifid_en     = 1'b1;
        hif.idex_en     = 1'b1;
        hif.exmem_en    = 1'b1;
        hif.memwb_en    = 1'b1;
        hif.ifid_flush  = 1'b0;
        hif.idex_flush  = 1'b0;
        hif.exmem_flush = 1'b0;
        hif.halted      = 1'b0;

        if (!RST) begin
            if (hif.wb_halt || state_q == StHalt) begin
                {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en} = '0;
                hif.halted = 1'b1;
                state_d    = StHalt;
            end else begin
                unique case (state_q)
                    StRun: begin
                        if (dmiss) begin
                            {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en} = '0;
                            hif.exmem_flush = 1'b1;
                            saved_d         = StRun;
                            state_d         = StMemWait;
                        end else if (bl || lu || ba || bm) begin
                            hif.pc_en      = 1'b0;
                            hif.ifid_en    = 1'b0;
                            hif.idex_flush = 1'b1;
                            if (bl) begin
                                state_d = StStall;
                                rem_d   = 2'd1;
                            end
                        end else if (!hif.ihit) begin
                            hif.pc_en      = 1'b0;
                            hif.ifid_flush = 1'b1;
                        end else if (hif.id_taken) begin
                            hif.ifid_flush = 1'b1;
                        end
                    end
                    StStall: begin
                        if (dmiss) begin
                            {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en} = '0;
                            hif.exmem_flush = 1'b1;
                            saved_d         = StStall;
                            state_d         = StMemWait;
                        end else begin
                            hif.pc_en      = 1'b0;
                            hif.ifid_en    = 1'b0;
                            hif.idex_flush = 1'b1;
                            rem_d          = (rem_q != 2'd0) ? rem_q - 2'd1 : 2'd0;
                            if (rem_d == 2'd0) state_d = StRun;
                        end
                    end
                    StMemWait: begin
                        {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en} = '0;
                        hif.exmem_flush = 1'b1;
                        // Let the completed access retire into MEM/WB while EX/MEM takes a bubble.
                        if (hif.dhit) begin
                            hif.memwb_en = 1'b1;
                            state_d      = saved_q;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StRun;
            saved_q <= StRun;
            rem_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            rem_q   <= rem_d;
            if (!hif.pc_en && !hif.halted && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hif.stall_cycles = cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: interlocks, dcache freeze, halt, reset and counter saturation.
module tb_hazard_unit;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    hazard_unit_if #(.CNT_W(16)) hif ();
    hazard_unit_if #(.CNT_W(4))  sif ();

    hazard_unit #(.CNT_W(16)) dut     (.CLK(CLK), .RST(RST), .hif(hif));
    hazard_unit #(.CNT_W(4))  dut_sat (.CLK(CLK), .RST(RST), .hif(sif));

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, halted}
    logic [8:0] obs;
    assign obs = {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
                  hif.ifid_flush, hif.idex_flush, hif.exmem_flush, hif.halted};

    localparam logic [8:0] RunOk  = 9'b11111_000_0;
    localparam logic [8:0] Stall  = 9'b00111_010_0;
    localparam logic [8:0] Freeze = 9'b00000_001_0;
    localparam logic [8:0] DhitV  = 9'b00001_001_0;
    localparam logic [8:0] HaltV  = 9'b00000_000_1;
    localparam logic [8:0] NoIhit = 9'b01111_100_0;
    localparam logic [8:0] Taken  = 9'b11111_100_0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        hif.ihit = 1'b1; hif.dhit = 1'b1; hif.id_rs = 5'd0; hif.id_rt = 5'd0;
        hif.id_uses_rt = 1'b0; hif.id_branch = 1'b0; hif.id_taken = 1'b0;
        hif.ex_wsel = 5'd0; hif.ex_regwr = 1'b0; hif.ex_memread = 1'b0;
        hif.mem_wsel = 5'd0; hif.mem_memread = 1'b0; hif.mem_memop = 1'b0; hif.wb_halt = 1'b0;
        sif.ihit = 1'b1; sif.dhit = 1'b1; sif.id_rs = 5'd0; sif.id_rt = 5'd0;
        sif.id_uses_rt = 1'b0; sif.id_branch = 1'b0; sif.id_taken = 1'b0;
        sif.ex_wsel = 5'd0; sif.ex_regwr = 1'b0; sif.ex_memread = 1'b0;
        sif.mem_wsel = 5'd0; sif.mem_memread = 1'b0; sif.mem_memop = 1'b0; sif.wb_halt = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        RST = 1'b1;
        hif.wb_halt = 1'b1; hif.ex_memread = 1'b1; hif.ex_wsel = 5'd5; hif.id_rs = 5'd5;
        tick();
        n_checks++;
        if (obs !== RunOk) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, RunOk); end
        n_checks++;
        if (hif.stall_cycles !== 16'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", hif.stall_cycles);
        end
        idle();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_load_use();
        do_reset();
        hif.ex_memread = 1'b1; hif.ex_wsel = 5'd5; hif.id_rs = 5'd5;
        #1;
        n_checks++;
        if (obs !== Stall) begin n_fail++; $display("FAIL lu_stall: got %b want %b", obs, Stall); end
        tick();
        idle();
        #1;
        n_checks++;
        if (obs !== RunOk) begin n_fail++; $display("FAIL lu_release: got %b want %b", obs, RunOk); end
        n_checks++;
        if (hif.stall_cycles !== 16'd1) begin
            n_fail++; $display("FAIL lu_count: got %0d want 1", hif.stall_cycles);
        end
    endtask

    task automatic test_hazards();
        do_reset();
        // rt match ignored when the instruction does not read rt
        hif.ex_memread = 1'b1; hif.ex_wsel = 5'd6; hif.id_rt = 5'd6; hif.id_rs = 5'd1; #1;
        n_checks++;
        if (obs !== RunOk) begin n_fail++; $display("FAIL lu_no_rt: got %b want %b", obs, RunOk); end
        hif.id_uses_rt = 1'b1; #1;
        n_checks++;
        if (obs !== Stall) begin n_fail++; $display("FAIL lu_rt: got %b want %b", obs, Stall); end
        idle(); hif.ex_memread = 1'b1; hif.ex_wsel = 5'd0; hif.id_rs = 5'd0; #1;
        n_checks++;
        if (obs !== RunOk) begin n_fail++; $display("FAIL lu_r0: got %b want %b", obs, RunOk); end
        idle(); hif.id_branch = 1'b1; hif.id_taken = 1'b1; hif.ex_regwr = 1'b1;
        hif.ex_wsel = 5'd3; hif.id_rs = 5'd3; #1;
        n_checks++;
        if (obs !== Stall) begin n_fail++; $display("FAIL ba_stall: got %b want %b", obs, Stall); end
        hif.id_branch = 1'b0; #1;
        n_checks++;
        if (obs !== Taken) begin n_fail++; $display("FAIL alu_nobranch: got %b want %b", obs, Taken); end
        idle(); hif.id_branch = 1'b1; hif.mem_memread = 1'b1; hif.mem_wsel = 5'd4; hif.id_rt = 5'd4; #1;
        n_checks++;
        if (obs !== Stall) begin n_fail++; $display("FAIL bm_stall: got %b want %b", obs, Stall); end
        idle(); hif.ihit = 1'b0; hif.id_taken = 1'b1; #1;
        n_checks++;
        if (obs !== NoIhit) begin n_fail++; $display("FAIL no_ihit: got %b want %b", obs, NoIhit); end
        idle(); hif.id_taken = 1'b1; #1;
        n_checks++;
        if (obs !== Taken) begin n_fail++; $display("FAIL taken: got %b want %b", obs, Taken); end
        idle(); hif.mem_memop = 1'b1; hif.dhit = 1'b0; hif.id_branch = 1'b1;
        hif.ex_memread = 1'b1; hif.ex_wsel = 5'd8; hif.id_rt = 5'd8; #1;
        n_checks++;
        if (obs !== Freeze) begin n_fail++; $display("FAIL miss_over_bl: got %b want %b", obs, Freeze); end
        idle(); #1;
    endtask

    task automatic test_branch_load();
        do_reset();
        hif.id_branch = 1'b1; hif.id_rt = 5'd8; hif.ex_memread = 1'b1; hif.ex_wsel = 5'd8; #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs !== Stall) begin n_fail++; $display("FAIL bl_stall%0d: got %b want %b", i, obs, Stall); end
            tick();
            hif.ex_memread = 1'b0; #1;
        end
        idle(); #1;
        n_checks++;
        if (obs !== RunOk) begin n_fail++; $display("FAIL bl_release: got %b want %b", obs, RunOk); end
        n_checks++;
        if (hif.stall_cycles !== 16'd2) begin
            n_fail++; $display("FAIL bl_count: got %0d want 2", hif.stall_cycles);
        end
    endtask

    task automatic test_dmiss();
        do_reset();
        hif.mem_memop = 1'b1; hif.dhit = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs !== Freeze) begin n_fail++; $display("FAIL miss_freeze%0d: got %b want %b", i, obs, Freeze); end
            tick();
        end
        hif.dhit = 1'b1; #1;
        n_checks++;
        if (obs !== DhitV) begin n_fail++; $display("FAIL miss_dhit: got %b want %b", obs, DhitV); end
        tick();
        idle(); #1;
        n_checks++;
        if (obs !== RunOk) begin n_fail++; $display("FAIL miss_release: got %b want %b", obs, RunOk); end
        n_checks++;
        if (hif.stall_cycles !== 16'd4) begin
            n_fail++; $display("FAIL miss_count: got %0d want 4", hif.stall_cycles);
        end
    endtask

    task automatic test_stall_miss();
        do_reset();
        hif.id_branch = 1'b1; hif.id_rs = 5'd9; hif.ex_memread = 1'b1; hif.ex_wsel = 5'd9; #1;
        tick();
        idle(); hif.mem_memop = 1'b1; hif.dhit = 1'b0; #1;
        n_checks++;
        if (obs !== Freeze) begin n_fail++; $display("FAIL sm_freeze: got %b want %b", obs, Freeze); end
        tick();
        hif.dhit = 1'b1; #1;
        n_checks++;
        if (obs !== DhitV) begin n_fail++; $display("FAIL sm_dhit: got %b want %b", obs, DhitV); end
        tick();
        idle(); #1;
        n_checks++;
        if (obs !== Stall) begin n_fail++; $display("FAIL sm_resume: got %b want %b", obs, Stall); end
        tick();
        n_checks++;
        if (obs !== RunOk) begin n_fail++; $display("FAIL sm_release: got %b want %b", obs, RunOk); end
        n_checks++;
        if (hif.stall_cycles !== 16'd4) begin
            n_fail++; $display("FAIL sm_count: got %0d want 4", hif.stall_cycles);
        end
    endtask

    task automatic test_halt();
        int bad;
        do_reset();
        hif.wb_halt = 1'b1; hif.mem_memop = 1'b1; hif.dhit = 1'b0; #1;
        n_checks++;
        if (obs !== HaltV) begin n_fail++; $display("FAIL halt_enter: got %b want %b", obs, HaltV); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            idle();
            hif.ihit = i[0]; hif.dhit = i[1]; hif.mem_memop = i[2]; hif.id_branch = 1'b1;
            hif.ex_memread = 1'b1; hif.ex_wsel = 5'd2; hif.id_rs = 5'd2; hif.id_taken = i[0];
            #1;
            if (obs !== HaltV || hif.stall_cycles !== 16'd0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL halt_hold: got %0d bad cycles want 0", bad); end
        RST = 1'b1; #1;
        n_checks++;
        if (obs !== RunOk) begin n_fail++; $display("FAIL halt_reset: got %b want %b", obs, RunOk); end
        tick();
        RST = 1'b0; idle(); #1;
        n_checks++;
        if (obs !== RunOk || hif.stall_cycles !== 16'd0) begin
            n_fail++; $display("FAIL halt_release: got %b/%0d want %b/0", obs, hif.stall_cycles, RunOk);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        hif.id_branch = 1'b1; hif.id_rs = 5'd7; hif.ex_memread = 1'b1; hif.ex_wsel = 5'd7; #1;
        tick();
        RST = 1'b1; idle(); #1;
        n_checks++;
        if (obs !== RunOk) begin n_fail++; $display("FAIL rst_in_stall: got %b want %b", obs, RunOk); end
        tick();
        RST = 1'b0; #1;
        n_checks++;
        if (obs !== RunOk) begin n_fail++; $display("FAIL rst_stall_after: got %b want %b", obs, RunOk); end
        hif.mem_memop = 1'b1; hif.dhit = 1'b0; #1;
        tick();
        RST = 1'b1; #1;
        tick();
        RST = 1'b0; idle(); #1;
        n_checks++;
        if (obs !== RunOk) begin n_fail++; $display("FAIL rst_memwait_after: got %b want %b", obs, RunOk); end
    endtask

    task automatic test_saturation();
        int want;
        do_reset();
        sif.ihit = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            want = (i > 15) ? 15 : i;
            n_checks++;
            if (sif.stall_cycles !== 4'(want)) begin
                n_fail++; $display("FAIL sat_count%0d: got %0d want %0d", i, sif.stall_cycles, want);
            end
        end
        idle(); #1;
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_hazards();
        test_branch_load();
        test_dmiss();
        test_stall_miss();
        test_halt();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the stall-cycle counter.
REQ-002 SHALL have ports, one per line: name direction width meaning.
- CLK in 1 -- pipeline clock, rising-edge.
- RST in 1 -- reset, asynchronous and active-high.
- ihit in 1 -- instruction fetch complete this cycle.
- dhit in 1 -- data access complete this cycle.
- id_rs, id_rt in 5 -- source registers of the instruction in ID.
- id_uses_rt in 1 -- the ID instruction reads rt.
- id_branch in 1 -- the ID instruction is a beq, bne or jr, resolved in ID.
- id_taken in 1 -- the ID branch or jump redirects the PC.
- ex_wsel in 5 -- destination register in EX.
- ex_regwr in 1 -- EX instruction writes a register.
- ex_memread in 1 -- EX instruction is a load.
- mem_wsel in 5 -- destination register in MEM.
- mem_memread in 1 -- MEM instruction is a load.
- mem_memop in 1 -- MEM instruction accesses dcache.
- wb_halt in 1 -- halt instruction reached WB.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en out 1 each -- stage register enables.
- ifid_flush, idex_flush, exmem_flush out 1 each -- insert a bubble into that register.
- halted out 1 -- the core is halted.
- stall_cycles out CNT_W -- saturating count of stalled cycles.

Function
REQ-003 SHALL implement FSM states RUN, STALL, MEMWAIT and HALT, plus a 2-bit remaining-count register rem and a 2-bit saved-state register.
REQ-004 SHALL define the hazard conditions as follows; each match also requires the compared source register to be nonzero.
- LU: ex_memread and ex_wsel nonzero and (ex_wsel==id_rs or (id_uses_rt and ex_wsel==id_rt)).
- BL (branch after load in EX): id_branch and ex_memread and ex_wsel matches id_rs or id_rt.
- BA (branch after ALU in EX): id_branch and ex_regwr and not ex_memread and ex_wsel matches.
- BM (branch after load in MEM): id_branch and mem_memread and mem_wsel matches.
REQ-005 SHALL define the stall outputs as pc_en=0, ifid_en=0, idex_flush=1, with exmem_en=1 and memwb_en=1.
REQ-006 SHALL define the freeze outputs as all five enables 0, exmem_flush=1 and all other flushes 0.
REQ-007 SHALL in RUN apply priority wb_halt > (mem_memop and not dhit) > BL > LU, BA or BM > not ihit > id_taken.
REQ-008 SHALL on wb_halt in any state drive the freeze outputs with exmem_flush=0, set halted=1 and enter HALT the same cycle.
REQ-009 SHALL on (mem_memop and not dhit) in RUN drive the freeze outputs, store RUN as the saved state and enter MEMWAIT.
REQ-010 SHALL on BL in RUN drive the stall outputs, enter STALL and set rem=1, for 2 stall cycles total.
REQ-011 SHALL on LU, BA or BM in RUN drive the stall outputs and stay in RUN, for 1 stall cycle.
REQ-012 SHALL on (not ihit) with no other hazard drive pc_en=0 and ifid_flush=1 while all other enables stay 1.
REQ-013 SHALL on id_taken with no other hazard and ihit=1 drive ifid_flush=1 with all enables 1.
REQ-014 SHALL in STALL drive the stall outputs, decrement rem and return to RUN when rem reaches 0.
REQ-015 SHALL on a dcache miss during STALL enter MEMWAIT with rem held and STALL stored as the saved state.
REQ-016 SHALL in MEMWAIT drive the freeze outputs until dhit=1.
REQ-017 SHALL in the dhit cycle of MEMWAIT set memwb_en=1, exmem_flush=1 and other enables 0, then return to the saved state.
REQ-018 SHALL remain in HALT with all enables 0 until reset, ignoring every other input.
REQ-019 SHALL increment stall_cycles by 1 in each cycle with pc_en=0 outside HALT, saturating at all-ones with no wrap.
REQ-020 SHALL make all outputs Mealy outputs of state and inputs, with zero-cycle latency from hazard detection.

Reset
REQ-021 SHALL on RST=1 immediately set state=RUN, rem=0, saved state=RUN, stall_cycles=0 and halted=0.
REQ-022 SHALL while RST=1 drive all enables to 1 and all flushes to 0.
REQ-023 SHALL on RST asserted mid-STALL or mid-MEMWAIT abandon the pending stall or wait, with no residual stall after release.

Verification
REQ-024 SHALL cover load-use: ex_memread=1, ex_wsel=5, id_rs=5 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1, then pc_en=1, and stall_cycles=1.
REQ-025 SHALL cover branch after load: id_branch=1, id_rt=8, ex_memread=1, ex_wsel=8 -> exactly 2 stall cycles, then RUN, and stall_cycles=2.
REQ-026 SHALL cover a dcache miss: mem_memop=1, dhit=0 for 3 cycles, then dhit=1 -> 3 freeze cycles, then one cycle with memwb_en=1 and exmem_flush=1.
REQ-027 SHALL cover a miss during STALL: dhit=0 in the 2nd BL stall cycle -> MEMWAIT; after dhit, 1 further stall cycle, then RUN.
REQ-028 SHALL cover halt: wb_halt=1 -> halted=1 with all enables 0, held for 10 cycles regardless of inputs; RST=1 -> halted=0 and stall_cycles=0.
REQ-029 SHALL cover saturation: CNT_W=4 with 20 consecutive stall cycles -> stall_cycles holds at 15.
